tmds_word_align: RTL
====================

// Module: tmds_word_align
//
// PURPOSE
//  Word-alignment controller for one HDMI/DVI receive channel. It sits between
//  the 10:1 deserializer and the TMDS decoder, and re-frames the raw 10-bit
//  stream through a 0..9 bit barrel window. It searches for a run of TMDS
//  control-period tokens at each offset, steps the offset on timeout, declares
//  lock, and drops lock when control periods stop arriving.
//
// PARAMETERS
//  MIN_RUN         8      consecutive control tokens required to lock / refresh
//  SEARCH_TIMEOUT  4096   words tried at one offset before stepping (> 1 line)
//  LOSS_TIMEOUT    16384  words without a qualifying run before lock is dropped
//
// PORTS
//  i_clk       in   1   word clock
//  i_areset_n  in   1   asynchronous, active-low reset
//  i_word      in   10  raw deserializer word, arbitrary framing
//  i_resync    in   1   one-cycle request: drop lock, restart search at current offset
//  o_word      out  10  re-framed word, decoder bit order
//  o_locked    out  1   alignment established
//  o_shift     out  4   current window offset, 0..9
//  o_slip      out  1   one-cycle pulse when the offset advances
//  o_ctl       out  1   o_word is a control token (registered with o_word)
//
// BEHAVIOUR
//  - Reset (async assert, sync release): o_word=0, o_locked=0, o_shift=0,
//    o_slip=0, o_ctl=0, state=SEARCH, all counters 0.
//  - Datapath: r_prev<=i_word each cycle; cat={i_word,r_prev} (20b);
//    o_word<=cat[o_shift +: 10]. With shift 0, o_word(t+2)=i_word(t).
//    Latency is 2 cycles for every offset.
//  - Control tokens in o_word order: 10'h0ab, 10'h354, 10'h0aa, 10'h355.
//    o_ctl is set the same cycle o_word takes a control-token value.
//  - run_cnt: increments on o_ctl and clears on !o_ctl. It saturates at MIN_RUN.
//    run_hit = (run_cnt == MIN_RUN-1) && o_ctl, which marks the MIN_RUN-th
//    consecutive token.
//  - States:
//    SEARCH: tmo_cnt++ each cycle.
//      * On run_hit: go to LOCKED, o_locked<=1, loss_cnt<=0.
//      * Else, when tmo_cnt==SEARCH_TIMEOUT-1: o_shift<=(o_shift==9)?0:o_shift+1,
//        o_slip<=1 for one cycle, tmo_cnt<=0, run_cnt<=0, go to SETTLE.
//    SETTLE: ignores o_ctl and holds run_cnt=0 for 3 cycles, which flushes the
//      pipeline. Then go to SEARCH.
//    LOCKED: loss_cnt++ each cycle. run_hit sets loss_cnt<=0.
//      * When loss_cnt==LOSS_TIMEOUT-1 and there is no run_hit in that cycle:
//        o_locked<=0, go to SEARCH with tmo_cnt=0 and o_shift unchanged.
//  - i_resync: from any state, next cycle is SEARCH with o_locked=0, tmo_cnt=0,
//    run_cnt=0, o_shift unchanged, and no o_slip. It overrides run_hit and
//    timeout in the same cycle.
//  - A run_hit in the same cycle as an SEARCH timeout: lock wins and no slip
//    occurs.
//  - o_shift never exceeds 9. The step from 9 wraps to 0.
//  - Reset asserted mid-lock: all outputs go to reset values immediately.
//  - Counter widths are $clog2 of the respective limit. Counters never wrap
//    because every limit is caught by ==limit-1.
//
// STRUCTURE
//  - Shared package tmds_pkg: the four control-token constants and a state
//    enum/localparams (SEARCH, SETTLE, LOCKED). The TMDS decoder reuses the
//    tokens.
//  - One sub-module: tmds_barrel10. It is the registered 20->10 window select:
//    i_clk, i_areset_n, i_word, i_shift -> o_word.
//  - FSM and counters live in this file.
//
// TESTING  (small parameters: MIN_RUN=4, SEARCH_TIMEOUT=64, LOSS_TIMEOUT=256)
//  1. Serial stream of 12-token 10'h354 runs every 50 words, misframed by 3
//     bits -> o_shift steps 0,1,2,3 with one o_slip each, then o_locked=1 at
//     o_shift=3 and o_word=10'h354.
//  2. Random non-control data for 700 words -> o_slip every 67 cycles
//     (64 + 3 settle), o_shift wraps 9->0, and o_locked stays 0.
//  3. Aligned stream with a run of exactly 3 tokens -> no lock. A 4-token
//     run -> o_locked rises 3 cycles after the 4th token enters i_word.
//  4. Locked, then control runs stop -> o_locked falls after 256 words and
//     o_shift is unchanged.
//  5. Locked, pulse i_resync in the same cycle as a run_hit -> o_locked=0
//     next cycle, no o_slip, then relock on the following run.
//  6. Deassert i_areset_n mid-lock -> all outputs 0 asynchronously. Lock
//     recovers after release.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the receive path.
//
// Contents:
//   CTL_TOKEN_0..3   the four control-period tokens, in decoder bit order
//   align_state_e    word-aligner state (SEARCH, SETTLE, LOCKED)
//   SETTLE_CYCLES    cycles spent flushing the window pipeline after a slip
//   is_ctl_token()   true when a 10-bit word is one of the control tokens
//
// The TMDS decoder imports the same token constants.
package tmds_pkg;

  localparam logic [9:0] CTL_TOKEN_0 = 10'h0ab;
  localparam logic [9:0] CTL_TOKEN_1 = 10'h354;
  localparam logic [9:0] CTL_TOKEN_2 = 10'h0aa;
  localparam logic [9:0] CTL_TOKEN_3 = 10'h355;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

  localparam int SETTLE_CYCLES = 3;

  function automatic logic is_ctl_token(input logic [9:0] word);
    return (word == CTL_TOKEN_0) || (word == CTL_TOKEN_1) ||
           (word == CTL_TOKEN_2) || (word == CTL_TOKEN_3);
  endfunction

endpackage

// File: rtl/tmds_barrel10.sv
// Registered 20->10 bit window select for one TMDS channel.
//
// Ports:
//   i_clk       word clock
//   i_areset_n  asynchronous active-low reset
//   i_word      raw deserializer word, arbitrary framing
//   i_shift     window offset 0..9
//   o_word      re-framed word, two cycles after the first bits enter i_word
//
// The window is taken from {i_word, previous word}, so offset 0 returns the
// previous word unchanged and every offset has the same two-cycle latency.
module tmds_barrel10 (
  input  logic       i_clk,
  input  logic       i_areset_n,
  input  logic [9:0] i_word,
  input  logic [3:0] i_shift,
  output logic [9:0] o_word
);

  logic [9:0]  prev_q, prev_d;
  logic [9:0]  word_q, word_d;
  logic [19:0] cat;

  always_comb begin
    prev_d = i_word;
    cat    = {i_word, prev_q};
    // A right shift keeps the select in range for any 4-bit offset.
    word_d = 10'(cat >> i_shift);
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values; blocking here would let prev_q leak into word_q early.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      prev_q <= '0;
      word_q <= '0;
    end else begin
      prev_q <= prev_d;
      word_q <= word_d;
    end
  end

  assign o_word = word_q;

endmodule

// File: rtl/tmds_word_align.sv
// Word-alignment controller for one HDMI/DVI receive channel.
//
// Re-frames the raw deserializer stream through a 0..9 bit window, hunts for
// a run of MIN_RUN consecutive control tokens at each offset, steps the offset
// after SEARCH_TIMEOUT words without one, and drops lock after LOSS_TIMEOUT
// words without a fresh qualifying run.
//
// Ports:
//   i_clk       word clock
//   i_areset_n  asynchronous active-low reset
//   i_word      raw 10-bit deserializer word
//   i_resync    one-cycle request: drop lock, restart search at current offset
//   o_word      re-framed word (2-cycle latency)
//   o_locked    alignment established
//   o_shift     current window offset 0..9
//   o_slip      one-cycle pulse when the offset advances
//   o_ctl       o_word is a control token
module tmds_word_align
  import tmds_pkg::*;
#(
  parameter int MIN_RUN        = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT   = 16384
) (
  input  logic       i_clk,
  input  logic       i_areset_n,
  input  logic [9:0] i_word,
  input  logic       i_resync,
  output logic [9:0] o_word,
  output logic       o_locked,
  output logic [3:0] o_shift,
  output logic       o_slip,
  output logic       o_ctl
);

  // run_cnt saturates at MIN_RUN itself, so it needs one extra code point.
  localparam int RUN_W  = $clog2(MIN_RUN + 1);
  localparam int TMO_W  = $clog2(SEARCH_TIMEOUT);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT);

  localparam logic [RUN_W-1:0]  RUN_LAST    = RUN_W'(MIN_RUN - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX     = RUN_W'(MIN_RUN);
  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST   = LOSS_W'(LOSS_TIMEOUT - 1);
  localparam logic [1:0]        SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  align_state_e      state_q, state_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d, run_adv;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
  logic [1:0]        settle_cnt_q, settle_cnt_d;
  logic [3:0]        shift_q, shift_d;
  logic              locked_q, locked_d;
  logic              slip_q, slip_d;
  logic              ctl;
  logic              run_hit;

  tmds_barrel10 u_barrel (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .i_word     (i_word),
    .i_shift    (shift_q),
    .o_word     (o_word)
  );

  // Decoded straight from the registered window, so it changes on the same
  // edge as o_word.
  assign ctl     = is_ctl_token(o_word);
  assign run_hit = ctl && (run_cnt_q == RUN_LAST);

  // NOTE: every output of this block is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    settle_cnt_d = settle_cnt_q;
    shift_d      = shift_q;
    locked_d     = locked_q;
    slip_d       = 1'b0;

    if (!ctl)                  run_adv = '0;
    else if (run_cnt_q == RUN_MAX) run_adv = run_cnt_q;
    else                       run_adv = run_cnt_q + 1'b1;

    if (i_resync) begin
      state_d      = ST_SEARCH;
      locked_d     = 1'b0;
      tmo_cnt_d    = '0;
      run_cnt_d    = '0;
      loss_cnt_d   = '0;
      settle_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_SEARCH: begin
          run_cnt_d = run_adv;
          // Lock takes priority over a timeout landing in the same cycle.
          if (run_hit) begin
            state_d    = ST_LOCKED;
            locked_d   = 1'b1;
            loss_cnt_d = '0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            shift_d      = (shift_q == 4'd9) ? 4'd0 : shift_q + 4'd1;
            slip_d       = 1'b1;
            tmo_cnt_d    = '0;
            run_cnt_d    = '0;
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          // Words still in flight were framed at the old offset; ignore them.
          run_cnt_d = '0;
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_d = '0;
            tmo_cnt_d    = '0;
            state_d      = ST_SEARCH;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          run_cnt_d = run_adv;
          if (run_hit) begin
            loss_cnt_d = '0;
          end else if (loss_cnt_q == LOSS_LAST) begin
            locked_d  = 1'b0;
            tmo_cnt_d = '0;
            state_d   = ST_SEARCH;
          end else begin
            loss_cnt_d = loss_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q      <= ST_SEARCH;
      run_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      loss_cnt_q   <= '0;
      settle_cnt_q <= '0;
      shift_q      <= '0;
      locked_q     <= 1'b0;
      slip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      shift_q      <= shift_d;
      locked_q     <= locked_d;
      slip_q       <= slip_d;
    end
  end

  assign o_locked = locked_q;
  assign o_shift  = shift_q;
  assign o_slip   = slip_q;
  assign o_ctl    = ctl;

endmodule
